// File: rtl/pc_predict_unit.sv
// Next-fetch-PC predictor: jxx/call predicted taken, ret stalls until write-back,
// or with PC_PREDICT_RAS_EN defined a return-address stack plus an in-order ret check queue.
module pc_predict_unit #(
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       RET_Q_DEPTH = 4,
  parameter int unsigned       RAS_DEPTH   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic              f_stall,
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic [ADDR_W-1:0] m_valA,
  input  logic [3:0]        w_icode,
  input  logic [ADDR_W-1:0] w_valM,
  output logic [ADDR_W-1:0] f_pc,
  output logic              ret_stall,
  output logic              flush_jxx,
  output logic              flush_ret
);
  localparam logic [3:0] IC_JXX  = 4'd7;
  localparam logic [3:0] IC_CALL = 4'd8;
  localparam logic [3:0] IC_RET  = 4'd9;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("RAS_DEPTH must be a power of 2 and >= 2");
  end
  if (RET_Q_DEPTH < 2 || (RET_Q_DEPTH & (RET_Q_DEPTH - 1)) != 0) begin : g_bad_q_depth
    $error("RET_Q_DEPTH must be a power of 2 and >= 2");
  end

  logic [ADDR_W-1:0] pred_pc, pred_nxt, ras_top_addr;
  logic ret_pending, q_deq, pred_ret_miss, ret_can_predict;
  logic w_ret, pend_resolve, ret_redirect, jxx_redirect, redirect, fetch_go, fetch_ret;

  // A pending (unpredicted) ret resolves only once all older predicted rets have drained.
  assign w_ret        = (w_icode == IC_RET);
  assign pend_resolve = w_ret && !q_deq && ret_pending;
  assign ret_redirect = pred_ret_miss || pend_resolve;
  assign jxx_redirect = (m_icode == IC_JXX) && !m_cnd && !ret_redirect;
  assign redirect     = ret_redirect || jxx_redirect;
  assign fetch_go     = redirect || (!f_stall && !ret_pending);
  assign fetch_ret    = fetch_go && (f_icode == IC_RET);

  assign f_pc      = ret_redirect ? w_valM : (jxx_redirect ? m_valA : pred_pc);
  assign ret_stall = ret_pending;
  assign flush_jxx = jxx_redirect;
  assign flush_ret = pred_ret_miss;

  always_comb begin
    pred_nxt = f_valP;
    case (f_icode)
      IC_JXX, IC_CALL: pred_nxt = f_valC;
      IC_RET:          if (ret_can_predict) pred_nxt = ras_top_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_pc     <= RESET_PC;
      ret_pending <= 1'b0;
    end else begin
      if (fetch_go) pred_pc <= pred_nxt;
      if (fetch_ret && !ret_can_predict) ret_pending <= 1'b1;
      else if (redirect)                 ret_pending <= 1'b0;
    end
  end

`ifdef PC_PREDICT_RAS_EN
  localparam int unsigned     RAS_AW   = $clog2(RAS_DEPTH);
  localparam int unsigned     Q_AW     = $clog2(RET_Q_DEPTH);
  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW+1)'(RAS_DEPTH);
  localparam logic [Q_AW:0]   Q_FULL   = (Q_AW+1)'(RET_Q_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_top;
  logic [RAS_AW:0]   ras_cnt, ras_cnt_base;
  logic [ADDR_W-1:0] q_mem [RET_Q_DEPTH];
  logic [Q_AW-1:0]   q_head, q_tail;
  logic [Q_AW:0]     q_cnt, q_cnt_base;
  logic              flush_all, ras_push, ras_pop;

  // Occupancy as seen by the instruction fetched this cycle: after W dequeue and any flush.
  assign q_deq           = w_ret && (q_cnt != '0);
  assign pred_ret_miss   = q_deq && (q_mem[q_head] != w_valM);
  assign flush_all       = pred_ret_miss || jxx_redirect;
  assign ras_cnt_base    = flush_all ? '0 : ras_cnt;
  assign q_cnt_base      = flush_all ? '0 : q_cnt - (Q_AW+1)'(q_deq);
  assign ret_can_predict = (ras_cnt_base != '0) && (q_cnt_base != Q_FULL);
  assign ras_top_addr    = ras_mem[ras_top];
  assign ras_push        = fetch_go && (f_icode == IC_CALL);
  assign ras_pop         = fetch_ret && ret_can_predict;

  // Circular stack: a push when full silently overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_top <= '0;
      ras_cnt <= '0;
      q_head  <= '0;
      q_tail  <= '0;
      q_cnt   <= '0;
    end else begin
      if (ras_push) begin
        ras_top <= ras_top + RAS_AW'(1);
        ras_cnt <= (ras_cnt_base == RAS_FULL) ? RAS_FULL : ras_cnt_base + (RAS_AW+1)'(1);
      end else if (ras_pop) begin
        ras_top <= ras_top - RAS_AW'(1);
        ras_cnt <= ras_cnt_base - (RAS_AW+1)'(1);
      end else begin
        ras_cnt <= ras_cnt_base;
      end
      q_head <= flush_all ? q_tail : q_head + Q_AW'(q_deq);
      q_tail <= q_tail + Q_AW'(ras_pop);
      q_cnt  <= q_cnt_base + (Q_AW+1)'(ras_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_top + RAS_AW'(1)] <= f_valP;
    if (ras_pop)  q_mem[q_tail] <= ras_top_addr;
  end
`else
  assign q_deq           = 1'b0;
  assign pred_ret_miss   = 1'b0;
  assign ret_can_predict = 1'b0;
  assign ras_top_addr    = '0;
`endif
endmodule
